// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: one fetch/load/store at a time, IR/MDR capture, fault flagging.
// Optional ROM write protection is enabled by defining MEM_ROM_PROTECT_EN.
module mem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int ROM_WORDS   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_fetch,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              resp_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_* are sampled only on that edge and may
  // change freely afterwards. resp_valid is a single-cycle pulse, no back-pressure.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [31:0] ROM_W     = 32'(ROM_WORDS);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       is_write, is_fetch;
  logic [1:0] code_q, code_eval;
  logic       started;
  logic       accept;

  assign dbg_state = state;
  assign accept    = req_valid && req_ready;

  // Range check wins over the ROM check.
  always_comb begin
    code_eval = 2'b00;
    if (req_addr >= DEPTH_W)
      code_eval = 2'b01;
`ifdef MEM_ROM_PROTECT_EN
    else if (req_write && (req_addr < ROM_W))
      code_eval = 2'b10;
`else
    else
      code_eval = 2'b00;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    fault      = 1'b0;
    fault_code = 2'b00;
    case (state)
      IDLE: begin
        // started keeps ready low until the first edge after reset release
        req_ready = started;
        if (req_valid && started) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_read  = !is_write && (code_q == 2'b00);
        mem_write = is_write && (code_q == 2'b00) && (wait_cnt == WAIT_INIT);
        if (wait_cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        fault      = (code_q != 2'b00);
        fault_code = code_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      wait_cnt    <= 4'd0;
      is_write    <= 1'b0;
      is_fetch    <= 1'b0;
      code_q      <= 2'b00;
      mem_address <= 32'd0;
      mem_wdata   <= '0;
      ir_out      <= '0;
      mdr_out     <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        mem_address <= req_addr;
        mem_wdata   <= req_wdata;
        is_write    <= req_write;
        is_fetch    <= req_fetch;
        code_q      <= code_eval;
        wait_cnt    <= WAIT_INIT;
      end else if (state == ACCESS) begin
        if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
        end else if (!is_write && (code_q == 2'b00)) begin
          if (is_fetch) ir_out  <= mem_rdata;
          else          mdr_out <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 0 and 3), each with a memory
// model, checked against a transaction-level reference of memory, IR and MDR.
module tb_mem_access_ctrl;

`ifdef MEM_ROM_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_fetch [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] mem_address [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] ir_out    [2];
  logic [31:0] mdr_out   [2];
  logic        resp_valid [2];
  logic        fault     [2];
  logic [1:0]  fault_code [2];
  logic [1:0]  dbg_state [2];

  logic [31:0] mem     [2][32];
  logic [31:0] ref_mem [2][32];
  logic [31:0] exp_ir  [2];
  logic [31:0] exp_mdr [2];
  time         last_accept [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_ctrl #(.WAIT_CYCLES(g == 0 ? 0 : 3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_fetch(req_fetch[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .mem_address(mem_address[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .ir_out(ir_out[g]), .mdr_out(mdr_out[g]),
      .resp_valid(resp_valid[g]), .fault(fault[g]),
      .fault_code(fault_code[g]), .dbg_state(dbg_state[g])
    );
  end

  // Memory models: combinational read, posedge write.
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (mem_write[k] && mem_address[k] < 32) mem[k][mem_address[k][4:0]] <= mem_wdata[k];

  always_comb
    for (int k = 0; k < 2; k++)
      mem_rdata[k] = (mem_address[k] < 32) ? mem[k][mem_address[k][4:0]] : 32'h0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic do_req(input int k, input bit wr, input bit fetch,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int w, n, rd_cnt, wr_cnt, rdy_low, exp_rd, exp_wr;
    bit strobe_bad, fault_early, seen;
    logic [1:0] exp_code;
    w = wait_of(k);
    rd_cnt = 0; wr_cnt = 0; rdy_low = 0; strobe_bad = 0; fault_early = 0; seen = 0;
    if (addr >= 32) exp_code = 2'b01;
    else if (PROTECT && wr && addr < 16) exp_code = 2'b10;
    else exp_code = 2'b00;
    exp_rd = (!wr && exp_code == 2'b00) ? w + 1 : 0;
    exp_wr = (wr && exp_code == 2'b00) ? 1 : 0;

    req_valid[k] = 1'b1; req_write[k] = wr; req_fetch[k] = fetch;
    req_addr[k] = addr; req_wdata[k] = wdata;
    total++;
    if (req_ready[k] !== 1'b1) begin
      bad++; $display("FAIL ready_at_request inst=%0d got=%b want=1", k, req_ready[k]);
    end
    @(posedge clk);
    last_accept[k] = $time;
    #1;
    req_valid[k] = 1'b0; req_write[k] = 1'($urandom); req_fetch[k] = 1'($urandom);
    req_addr[k] = $urandom; req_wdata[k] = $urandom;

    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!req_ready[k]) rdy_low++;
      if (mem_read[k]) begin
        rd_cnt++;
        if (mem_address[k] !== addr) strobe_bad = 1;
      end
      if (mem_write[k]) begin
        wr_cnt++;
        if (mem_address[k] !== addr || mem_wdata[k] !== wdata) strobe_bad = 1;
      end
      if (resp_valid[k]) begin
        seen = 1;
        break;
      end
      if (fault[k] !== 1'b0 || fault_code[k] !== 2'b00) fault_early = 1;
    end

    total++;
    if (!seen) begin
      bad++; $display("FAIL resp_timeout inst=%0d addr=%0h no resp_valid in 40 cycles", k, addr);
      return;
    end
    if (n != w + 1) begin
      bad++; $display("FAIL resp_latency inst=%0d got=%0d want=%0d", k, n, w + 1);
    end
    total++;
    if (fault[k] !== (exp_code != 2'b00) || fault_code[k] !== exp_code) begin
      bad++; $display("FAIL fault inst=%0d addr=%0h wr=%0b got=%b/%b want=%b/%b", k, addr, wr,
                      fault[k], fault_code[k], exp_code != 2'b00, exp_code);
    end
    total++;
    if (rd_cnt != exp_rd || wr_cnt != exp_wr) begin
      bad++; $display("FAIL strobe_count inst=%0d addr=%0h rd=%0d wr=%0d want rd=%0d wr=%0d",
                      k, addr, rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
    total++;
    if (strobe_bad || fault_early) begin
      bad++; $display("FAIL strobe_payload inst=%0d addr=%0h payload_bad=%0b early_fault=%0b want 0/0",
                      k, addr, strobe_bad, fault_early);
    end
    total++;
    if (rdy_low != w + 2) begin
      bad++; $display("FAIL ready_low inst=%0d got=%0d want=%0d", k, rdy_low, w + 2);
    end

    if (exp_code == 2'b00) begin
      if (wr) ref_mem[k][addr[4:0]] = wdata;
      else if (fetch) exp_ir[k] = ref_mem[k][addr[4:0]];
      else exp_mdr[k] = ref_mem[k][addr[4:0]];
    end

    @(negedge clk);
    total++;
    if (ir_out[k] !== exp_ir[k] || mdr_out[k] !== exp_mdr[k]) begin
      bad++; $display("FAIL ir_mdr inst=%0d got ir=%h mdr=%h want ir=%h mdr=%h",
                      k, ir_out[k], mdr_out[k], exp_ir[k], exp_mdr[k]);
    end
    total++;
    if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || fault[k] !== 1'b0) begin
      bad++; $display("FAIL after_resp inst=%0d ready=%b resp=%b fault=%b want 1/0/0",
                      k, req_ready[k], resp_valid[k], fault[k]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({req_ready[k], mem_read[k], mem_write[k], resp_valid[k], fault[k], fault_code[k],
           mem_address[k], mem_wdata[k], ir_out[k], mdr_out[k]} !== '0) begin
        bad++; $display("FAIL %s inst=%0d ready=%b rd=%b wr=%b resp=%b fault=%b code=%b addr=%h wd=%h ir=%h mdr=%h want all 0",
                        tag, k, req_ready[k], mem_read[k], mem_write[k], resp_valid[k], fault[k],
                        fault_code[k], mem_address[k], mem_wdata[k], ir_out[k], mdr_out[k]);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_ir[k] = '0; exp_mdr[k] = '0;
      total++;
      if (req_ready[k] !== 1'b0) begin
        bad++; $display("FAIL ready_before_edge inst=%0d got=%b want=0", k, req_ready[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (req_ready[k] !== 1'b1) begin
        bad++; $display("FAIL ready_after_edge inst=%0d got=%b want=1", k, req_ready[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 2; k++) do_req(k, 1'b0, 1'b1, 32'd2, 32'h0);
  endtask

  task automatic test_load_wait();
    for (int k = 0; k < 2; k++) do_req(k, 1'b0, 1'b0, 32'd17, 32'h0);
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1'b1, 1'b0, 32'd18, 32'h5);
      do_req(k, 1'b0, 1'b0, 32'd18, 32'h0);
    end
  endtask

  task automatic test_fault_range();
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1'b0, 1'b0, 32'd40, 32'h0);
      do_req(k, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
      do_req(k, 1'b1, 1'b0, 32'd32, 32'h1234);
      do_req(k, 1'b1, 1'b0, 32'h8000_0003, 32'h77);
    end
  endtask

  task automatic test_rom_store();
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1'b1, 1'b0, 32'd3, 32'hABCD_0123);
      do_req(k, 1'b0, 1'b0, 32'd3, 32'h0);
      do_req(k, 1'b1, 1'b0, 32'd15, 32'h1);
      do_req(k, 1'b1, 1'b0, 32'd16, 32'h2);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1'b0, 1'b0, 32'd17, 32'h0);
      t0 = last_accept[k];
      do_req(k, 1'b0, 1'b1, 32'd2, 32'h0);
      total++;
      if (last_accept[k] - t0 != (wait_of(k) + 3) * 10) begin
        bad++; $display("FAIL back_to_back inst=%0d spacing=%0t want=%0d", k,
                        last_accept[k] - t0, (wait_of(k) + 3) * 10);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_fetch[1] = 1'b0;
    req_addr[1] = 32'd17; req_wdata[1] = 32'h0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    total++;
    if (mem_read[1] !== 1'b1) begin
      bad++; $display("FAIL mid_access_read got=%b want=1", mem_read[1]);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_access");
    @(posedge clk);
    release_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0) begin
        bad++; $display("FAIL dropped_resp cycle=%0d got=%b%b want=00", i, resp_valid[0], resp_valid[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        case ($urandom_range(0, 7))
          0:       addr = 32 + $urandom_range(0, 100);
          1:       addr = $urandom;
          default: addr = $urandom_range(0, 31);
        endcase
        do_req(k, 1'($urandom_range(0, 2) == 0), 1'($urandom), addr, $urandom);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_fetch[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;
      exp_ir[k] = '0; exp_mdr[k] = '0; last_accept[k] = 0;
    end
    for (int a = 0; a < 32; a++) begin
      ref_mem[0][a] = $urandom;
      ref_mem[1][a] = ref_mem[0][a];
    end
    for (int k = 0; k < 2; k++) begin
      ref_mem[k][2]  = 32'h8CE4_0002;
      ref_mem[k][17] = 32'd11;
      for (int a = 0; a < 32; a++) mem[k][a] = ref_mem[k][a];
    end

    test_reset();
    test_fetch();
    test_load_wait();
    test_store_load();
    test_fault_range();
    test_rom_store();
    test_back_to_back();
    test_reset_mid_access();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer between the multicycle control unit/datapath and the unified ROM/RAM memory (32 words: words 0-15 ROM, words 16-31 RAM, word-addressed, combinational read, posedge write).
- Accepts one fetch/load/store request at a time over a valid/ready handshake and drives the memory's address, read-enable, write-enable and write-data inputs.
- Captures returned data into the Instruction Register (fetch) or Memory Data Register (load) and flags illegal accesses.

Parameters:
- DATA_W, 32, data and instruction width
- DEPTH, 32, number of memory words; legal word addresses 0..DEPTH-1
- ROM_WORDS, 16, words 0..ROM_WORDS-1 form the ROM region
- WAIT_CYCLES, 0, extra ACCESS cycles inserted per request (0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = read
- req_fetch  in  1  read type: 1 = instruction fetch (IR), 0 = load (MDR); ignored when req_write=1
- req_addr  in  32  word address
- req_wdata  in  DATA_W  store data
- mem_address  out  32  to memory address
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_wdata  out  DATA_W  to memory write_data
- mem_rdata  in  DATA_W  from memory Mem_Data_Out
- ir_out  out  DATA_W  instruction register
- mdr_out  out  DATA_W  memory data register
- resp_valid  out  1  one-cycle completion pulse
- fault  out  1  qualifies resp_valid: the request was rejected
- fault_code  out  2  00 none, 01 address out of range, 10 ROM write

Behaviour:
Reset (rst high, asynchronous):
- All outputs go to 0 immediately.
- The state machine returns to IDLE and the wait counter clears.
- An in-flight request is dropped and no response is issued.
- req_ready rises on the first clock edge after rst is released.

States and transitions:
- IDLE:
  - req_ready = 1.
  - A handshake occurs when req_valid and req_ready are both high at a rising edge (the accept edge E0).
  - On E0, register req_addr into mem_address and req_wdata into mem_wdata, latch req_write/req_fetch, evaluate the fault, load wait counter = WAIT_CYCLES, and go to ACCESS.
- ACCESS:
  - req_ready = 0. Duration is WAIT_CYCLES+1 cycles.
  - Read with no fault: mem_read = 1 for every ACCESS cycle.
  - Store with no fault: mem_write = 1 only in the first ACCESS cycle, so exactly one memory write per store.
  - Fault: both strobes stay 0.
  - On the edge that ends the final ACCESS cycle, a fault-free read captures mem_rdata into ir_out (fetch) or mdr_out (load). Then go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with fault/fault_code valid in the same cycle.
  - req_ready = 0. Next state is IDLE.

Latency and handshake rules:
- resp_valid is high in the cycle beginning WAIT_CYCLES+1 edges after E0.
- Back-to-back throughput: one request per WAIT_CYCLES+3 cycles.
- req_* inputs are ignored outside the accept edge; later changes do not affect the transfer in flight.
- mem_address and mem_wdata hold their last value between requests.

Fault rules (evaluated at E0):
- req_addr >= DEPTH gives code 01. This check has priority over the ROM check.
- Store to a ROM address gives code 10 (see Optional Feature).
- On any fault, ir_out and mdr_out are unchanged.
- fault and fault_code are 0 outside RESP.

Other rules:
- ir_out and mdr_out hold their value until the next fault-free capture of the same type.
- Address comparisons are unsigned over the full 32 bits.

Optional Feature:
- Macro: MEM_ROM_PROTECT_EN.
- Defined: a store with req_addr < ROM_WORDS faults with code 10, and mem_write is never asserted.
- Undefined: ROM-region stores proceed as normal writes, and code 10 is never produced.

Test Plan:
- Reset during ACCESS of a load to word 17: strobes and outputs read 0 immediately, no resp_valid pulse, and req_ready is 1 one edge after release.
- WAIT_CYCLES=0, fetch from word 2 (memory returns 0x8CE40002): mem_read high for 1 cycle, resp_valid 1 edge after E0, ir_out=0x8CE40002, mdr_out unchanged, fault=0.
- WAIT_CYCLES=3, load from word 17 (value 11): mem_read high for 4 cycles, mdr_out=11, resp_valid 4 edges after E0, req_ready low for 5 cycles.
- Store 0x5 to word 18, then load word 18: mem_write high for exactly one cycle with mem_address=18 and mem_wdata=5, and the following load returns mdr_out=5.
- Load from word 40: no strobes, resp_valid with fault=1 and fault_code=01, mdr_out unchanged.
- Store to word 3: with MEM_ROM_PROTECT_EN, fault_code=10 and mem_write never asserted; without it, mem_write pulses once and fault=0.
